// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between N_REQ byte-stream sources
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   req_valid_i      per-requester byte valid
//   req_data_i       per-requester byte, requester i at [8i+7:8i]
//   req_last_i       per-requester end-of-packet marker for the presented byte
//   req_ready_o      byte accepted from the granted requester (one-hot or zero)
//   tx_start_o       single-cycle start pulse to uart_tx
//   tx_data_o        byte to uart_tx, zero when tx_start_o is low
//   tx_busy_i        uart_tx busy
//   grant_id_o       index of the current or most recent grantee
//   active_o         a packet is in progress
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int IDW       = $clog2(N_REQ),
    parameter bit HEADER_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_busy_i,
    output logic [IDW-1:0]     grant_id_o,
    output logic               active_o
);
    typedef enum logic [2:0] {IDLE, HDR_START, HDR_WAIT, DAT_START, DAT_WAIT} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, winner, idx;
    logic           last_q, last_d, guard_q, guard_d;
    logic           xfer, wait_done;
    logic [7:0]     gbyte;

    // Scan downward from rr_ptr+N to rr_ptr+1 so the closest set bit above rr_ptr wins last.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IDW'((int'(rr_ptr_q) + k) % N_REQ);
            if (req_valid_i[idx]) winner = idx;
        end
    end

    assign gbyte     = req_data_i[{grant_q, 3'b000} +: 8];
    assign xfer      = (state_q == DAT_START) && req_valid_i[grant_q];
    // The uart may not have raised busy yet in the first wait cycle, so that cycle is skipped.
    assign wait_done = !guard_q && !tx_busy_i;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        last_d   = last_q;
        guard_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_busy_i && |req_valid_i) begin
                    grant_d = winner;
                    state_d = HEADER_EN ? HDR_START : DAT_START;
                end
            end
            HDR_START: begin
                state_d = HDR_WAIT;
                guard_d = 1'b1;
            end
            HDR_WAIT: begin
                if (wait_done) state_d = DAT_START;
            end
            DAT_START: begin
                if (xfer) begin
                    last_d  = req_last_i[grant_q];
                    state_d = DAT_WAIT;
                    guard_d = 1'b1;
                end
            end
            DAT_WAIT: begin
                if (wait_done) begin
                    state_d = last_q ? IDLE : DAT_START;
                    if (last_q) rr_ptr_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IDW'(N_REQ - 1);
            last_q   <= 1'b0;
            guard_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            last_q   <= last_d;
            guard_q  <= guard_d;
        end
    end

    assign tx_start_o  = (state_q == HDR_START) || xfer;
    assign tx_data_o   = (state_q == HDR_START) ? (8'hA0 | 8'(grant_q)) : xfer ? gbyte : 8'h00;
    assign req_ready_o = (state_q == DAT_START) ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign grant_id_o  = grant_q;
    assign active_o    = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a busy-for-10-cycles uart model
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           tx_start, tx_busy, active;
    logic           force_busy = 1'b0;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;

    logic [N-1:0]   valid_b = '0, last_b = '0, ready_b;
    logic [8*N-1:0] data_b = '0;
    logic           start_b, active_b;
    logic [7:0]     dbyte_b;
    logic [1:0]     grant_b;

    int errors = 0, checks = 0, pulses = 0, pulses_b = 0, cnt = 0;
    logic        prev_start = 1'b0;
    logic [15:0] e_mon;
    logic [7:0]  e_b;
    logic [8:0]  mem [N][32];
    int          rd [N];
    int          wr [N] = '{0, 0, 0, 0};
    logic [15:0] exp_q [$];
    logic [7:0]  exp_b [$];

    uart_tx_arbiter #(.N_REQ(N), .HEADER_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .tx_start_o(tx_start), .tx_data_o(tx_data),
        .tx_busy_i(tx_busy), .grant_id_o(grant_id), .active_o(active)
    );

    uart_tx_arbiter #(.N_REQ(N), .HEADER_EN(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(valid_b), .req_data_i(data_b), .req_last_i(last_b),
        .req_ready_o(ready_b), .tx_start_o(start_b), .tx_data_o(dbyte_b),
        .tx_busy_i(1'b0), .grant_id_o(grant_b), .active_o(active_b)
    );

    always #5 clk = ~clk;

    // uart model: busy for 10 cycles after each start
    always @(posedge clk) begin
        if (tx_start) cnt <= 10;
        else if (cnt > 0) cnt <= cnt - 1;
    end
    assign tx_busy = force_busy | (cnt != 0);

    // byte sources: FIFO per requester; a source reset drops its pending bytes
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = rd[i] != wr[i];
            req_data[8*i +: 8]  = mem[i][rd[i]][7:0];
            req_last[i]         = mem[i][rd[i]][8];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) rd[i] <= wr[i];
        end else begin
            for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) rd[i] <= rd[i] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        mem[s][wr[s]] = {l, d};
        wr[s] = wr[s] + 1;
    endtask

    task automatic expect_tx(input int g, input logic [7:0] d);
        exp_q.push_back({8'(g), d});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || active || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, 32'(n < 3000), 1);
        @(negedge clk);
    endtask

    task automatic wait_pulses(input string name, input int target);
        int n = 0;
        while (pulses < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(pulses >= target), 1);
    endtask

    // monitor: every start pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (tx_start) begin
            pulses++;
            chk("no_back_to_back", 32'(prev_start), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx_start: got data %0h grant %0d, scoreboard empty", tx_data, grant_id);
            end else begin
                e_mon = exp_q.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e_mon[7:0]));
                chk("tx_grant", 32'(grant_id), 32'(e_mon[15:8]));
            end
        end
        prev_start = tx_start;
    end

    always @(negedge clk) begin
        if (start_b) begin
            pulses_b++;
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b_start: got data %0h, scoreboard empty", dbyte_b);
            end else begin
                e_b = exp_b.pop_front();
                chk("b_tx_data", 32'(dbyte_b), 32'(e_b));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, gp, n;
        logic held;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_active", 32'(active), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single packet from requester 0 with header
        p0 = pulses;
        expect_tx(0, 8'hA0); expect_tx(0, 8'h11); expect_tx(0, 8'h22); expect_tx(0, 8'h33);
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        wait_drain("t1");
        chk("t1_pulses", 32'(pulses - p0), 4);
        chk("t1_active", 32'(active), 0);

        // requesters 1 and 3 together from reset: round-robin 1,3,1,3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        p0 = pulses;
        expect_tx(1, 8'hA1); expect_tx(1, 8'h10); expect_tx(3, 8'hA3); expect_tx(3, 8'h30);
        expect_tx(1, 8'hA1); expect_tx(1, 8'h12); expect_tx(3, 8'hA3); expect_tx(3, 8'h32);
        push(1, 8'h10, 1'b1); push(1, 8'h12, 1'b1);
        push(3, 8'h30, 1'b1); push(3, 8'h32, 1'b1);
        wait_drain("t2");
        chk("t2_pulses", 32'(pulses - p0), 8);

        // requester 2 stalls mid-packet; requester 0 must wait for its last byte
        p0 = pulses;
        expect_tx(2, 8'hA2); expect_tx(2, 8'h21); expect_tx(2, 8'h22); expect_tx(2, 8'h23);
        expect_tx(0, 8'hA0); expect_tx(0, 8'h05);
        push(2, 8'h21, 1'b0);
        wait_pulses("t3_first_byte", p0 + 2);
        push(0, 8'h05, 1'b1);
        gp = pulses;
        held = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (grant_id != 2'd2 || !active) held = 1'b0;
        end
        chk("t3_gap_pulses", 32'(pulses), 32'(gp));
        chk("t3_grant_held", 32'(held), 1);
        push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
        wait_drain("t3");

        // busy held in IDLE blocks the grant; grant follows the fall
        force_busy = 1'b1;
        @(negedge clk);
        p0 = pulses;
        expect_tx(1, 8'hA1); expect_tx(1, 8'h44);
        push(1, 8'h44, 1'b1);
        repeat (5) @(negedge clk);
        chk("t4_active_blocked", 32'(active), 0);
        chk("t4_pulses_blocked", 32'(pulses - p0), 0);
        force_busy = 1'b0;
        @(negedge clk);
        chk("t4_active_after", 32'(active), 1);
        chk("t4_grant_after", 32'(grant_id), 1);
        wait_drain("t4");

        // reset during the second data byte's wait
        p0 = pulses;
        expect_tx(0, 8'hA0); expect_tx(0, 8'h61); expect_tx(0, 8'h62);
        push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0); push(0, 8'h63, 1'b1);
        wait_pulses("t5_second_byte", p0 + 3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx_start", 32'(tx_start), 0);
        chk("t5_rst_tx_data", 32'(tx_data), 0);
        chk("t5_rst_req_ready", 32'(req_ready), 0);
        chk("t5_rst_grant_id", 32'(grant_id), 0);
        chk("t5_rst_active", 32'(active), 0);
        chk("t5_scoreboard_empty", 32'(exp_q.size()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_tx(0, 8'hA0); expect_tx(0, 8'h71); expect_tx(2, 8'hA2); expect_tx(2, 8'h72);
        push(0, 8'h71, 1'b1); push(2, 8'h72, 1'b1);
        wait_drain("t5");

        // no header: a single byte 0x5A, start in the cycle after the grant edge
        exp_b.push_back(8'h5A);
        data_b[7:0] = 8'h5A;
        last_b[0]   = 1'b1;
        valid_b[0]  = 1'b1;
        n = 0;
        while (!start_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_latency", 32'(n), 1);
        @(posedge clk);
        #1 valid_b[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_pulses", 32'(pulses_b), 1);
        chk("t6_active", 32'(active_b), 0);
        chk("t6_scoreboard_empty", 32'(exp_b.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
